multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Control FSM that sequences the RV32I multi-cycle datapath: one shared memory for instructions and data, one ALU reused for PC+4, branch target and execute. Each instruction is split into Fetch/Decode/Execute/Memory/Writeback steps. The block replaces the single-cycle combinational decoder. Its inputs are instruction fields from the instruction register and the ALU zero flag. It drives every mux select, write enable and ALU operation of the datapath.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; FSM returns to FETCH
- op  in  7  Instr[6:0] from instruction register
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- zero  in  1  ALU zero flag, same cycle
- MemReady  in  1  memory handshake (present only with MC_MEMREADY_EN)
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0=PC, 1=Result
- MemWrite  out  1  data memory write strobe
- IRWrite  out  1  instruction register / OldPC enable
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=A (rs1)
- ALUSrcB  out  2  00=WriteData (rs2), 01=ImmExt, 10=constant 4
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- RegWrite  out  1  register file write enable
- Illegal  out  1  one-cycle pulse in DECODE for an unsupported op

## Operation
- Moore FSM. Outputs are decoded from the state register only, except PCWrite, ImmSrc and ALUControl, which also depend on op, funct3, funct7b5 and zero.
- Any output not listed for a state is 0.
- PCWrite = PCUpdate | (Branch & zero).
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10, PCUpdate=1. Next state: DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=add (branch target precompute). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - otherwise: Illegal=1, next FETCH (executes as NOP)
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=add. Next state: MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: ResultSrc=00, AdrSrc=1. Next state: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next state: FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. Next state: FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=funct. Next state: ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=funct. Next state: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next state: FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=00, Branch=1. Next state: FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=add, ResultSrc=00, PCUpdate=1. Next state: ALUWB.
- ImmSrc is decoded from op in every state: lw/I-type 00, sw 01, beq 10, jal 11, else 00.
- ALU decode:
  - ALUOp add -> 000; ALUOp sub -> 001
  - ALUOp funct, by funct3:
    - 000: sub if op[5]&funct7b5, else add
    - 010: slt
    - 110: or
    - 111: and
    - any other funct3: add

## Timing
- Reset value: state=FETCH.
- While reset=1, PCWrite, MemWrite, IRWrite and RegWrite are forced 0 regardless of state.
- Reset asserted mid-instruction aborts it; no partial writeback occurs after the reset edge.
- Cycles per instruction, without wait states: lw 5, sw 4, R 4, I 4, beq 3, jal 4, illegal 2.
- Branch resolves in the BEQ cycle: PCWrite is high in that same cycle iff zero=1.

## Configuration
- MC_MEMREADY_EN defined:
  - MemReady port exists.
  - FETCH, MEMREAD and MEMWRITE hold while MemReady=0.
  - While holding in FETCH, IRWrite and PCUpdate are gated by MemReady. No PC or IR update occurs until the ready cycle.
  - MemWrite stays asserted through a held MEMWRITE.
  - The state advances on the first edge with MemReady=1.
- MC_MEMREADY_EN undefined: no MemReady port; behaviour is identical to MemReady tied to 1.

## Structure
- Package mc_pkg contains:
  - state enum (FETCH … JAL)
  - opcode constants
  - ALUControl, ResultSrc, ALUSrcA and ALUSrcB encodings
  - ALUOp encoding (add/sub/funct)
- One sub-module, aludec (op[5], funct3, funct7b5, ALUOp -> ALUControl), is purely combinational.
- The FSM, output decode and ImmSrc decode stay in multicycle_controller.

## Test plan
- Reset held 2 cycles in any state -> state=FETCH; all strobes 0 during reset; first cycle after release has IRWrite=1, PCWrite=1.
- lw (op 0000011) -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 with ResultSrc=01 only in cycle 5; next FETCH in cycle 6.
- add/sub R-type, funct3=000 -> EXECR ALUControl=000 with funct7b5=0 and 001 with funct7b5=1; ALUWB RegWrite=1; 4 cycles total.
- beq with zero=1 -> PCWrite=1 in BEQ cycle (3rd); with zero=0 -> PCWrite=0; both return to FETCH.
- jal (1101111) -> ImmSrc=11; JAL state PCWrite=1, ALUSrcA=01, ALUSrcB=10; then ALUWB RegWrite=1.
- op=1111111 -> Illegal=1 in DECODE, FETCH next. With MC_MEMREADY_EN and MemReady low 3 cycles in MEMWRITE -> MemWrite high 4 cycles, single advance to FETCH.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the RV32I multi-cycle control FSM.
// Optional memory handshake is enabled with MC_MEMREADY_EN (see multicycle_controller).
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BEQ, JAL
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [2:0] ALUC_ADD = 3'b000;
  localparam logic [2:0] ALUC_SUB = 3'b001;
  localparam logic [2:0] ALUC_AND = 3'b010;
  localparam logic [2:0] ALUC_OR  = 3'b011;
  localparam logic [2:0] ALUC_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Moore outputs owned by a state; strobes are gated by reset/handshake in the top.
  typedef struct packed {
    logic       adrsrc;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       pcupdate;
    logic       branch;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    aluop_t     aluop;
  } ctl_t;

  function automatic ctl_t state_ctl(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.irwrite = 1'b1; c.pcupdate = 1'b1;
        c.alusrca = SRCA_PC; c.alusrcb = SRCB_FOUR; c.resultsrc = RES_ALURESULT;
      end
      DECODE:   begin c.alusrca = SRCA_OLDPC; c.alusrcb = SRCB_IMM; end
      MEMADR:   begin c.alusrca = SRCA_A; c.alusrcb = SRCB_IMM; end
      MEMREAD:  begin c.resultsrc = RES_ALUOUT; c.adrsrc = 1'b1; end
      MEMWB:    begin c.resultsrc = RES_DATA; c.regwrite = 1'b1; end
      MEMWRITE: begin c.resultsrc = RES_ALUOUT; c.adrsrc = 1'b1; c.memwrite = 1'b1; end
      EXECR:    begin c.alusrca = SRCA_A; c.alusrcb = SRCB_RS2; c.aluop = ALUOP_FUNCT; end
      EXECI:    begin c.alusrca = SRCA_A; c.alusrcb = SRCB_IMM; c.aluop = ALUOP_FUNCT; end
      ALUWB:    begin c.resultsrc = RES_ALUOUT; c.regwrite = 1'b1; end
      BEQ: begin
        c.alusrca = SRCA_A; c.alusrcb = SRCB_RS2; c.aluop = ALUOP_SUB;
        c.resultsrc = RES_ALUOUT; c.branch = 1'b1;
      end
      JAL: begin
        c.alusrca = SRCA_OLDPC; c.alusrcb = SRCB_FOUR;
        c.resultsrc = RES_ALUOUT; c.pcupdate = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [1:0] imm_src(logic [6:0] op);
    case (op)
      OP_SW:   return 2'b01;
      OP_BEQ:  return 2'b10;
      OP_JAL:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic legal_op(logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
           (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/multicycle_controller_aludec.sv
// ALU operation decoder: ALUOp plus instruction function fields -> ALUControl.
module aludec
  import mc_pkg::*;
(
  input  logic       opb5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  aluop_t     aluop,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALUC_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // only R-type (op[5]=1) distinguishes sub; addi ignores Instr[30]
          3'b000:  alucontrol = (opb5 & funct7b5) ? ALUC_SUB : ALUC_ADD;
          3'b010:  alucontrol = ALUC_SLT;
          3'b110:  alucontrol = ALUC_OR;
          3'b111:  alucontrol = ALUC_AND;
          default: alucontrol = ALUC_ADD;
        endcase
      end
      default: alucontrol = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM with registered Moore decode.
// Define MC_MEMREADY_EN to add the MemReady wait-state handshake.
module multicycle_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
`ifdef MC_MEMREADY_EN
  input  logic       MemReady,
`endif
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       Illegal
);

  state_t state_reg;
  state_t state_next;
  ctl_t   ctl_reg;
  logic   mem_ready;
  logic   fetch_gate;

`ifdef MC_MEMREADY_EN
  assign mem_ready = MemReady;
`else
  assign mem_ready = 1'b1;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH:  state_next = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECR;
          OP_I:         state_next = EXECI;
          OP_BEQ:       state_next = BEQ;
          OP_JAL:       state_next = JAL;
          default:      state_next = FETCH;
        endcase
      end
      MEMADR:   state_next = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  state_next = mem_ready ? MEMWB : MEMREAD;
      MEMWB:    state_next = FETCH;
      MEMWRITE: state_next = mem_ready ? FETCH : MEMWRITE;
      EXECR:    state_next = ALUWB;
      EXECI:    state_next = ALUWB;
      ALUWB:    state_next = FETCH;
      BEQ:      state_next = FETCH;
      JAL:      state_next = ALUWB;
      default:  state_next = FETCH;
    endcase
  end

  // Output register is loaded with the decode of the state being entered,
  // so it always matches state_reg.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= FETCH;
      ctl_reg   <= state_ctl(FETCH);
    end else begin
      state_reg <= state_next;
      ctl_reg   <= state_ctl(state_next);
    end
  end

  aludec u_aludec (
    .opb5       (op[5]),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .aluop      (ctl_reg.aluop),
    .alucontrol (ALUControl)
  );

  // While FETCH waits on memory, neither PC nor IR may move.
  assign fetch_gate = (state_reg != FETCH) | mem_ready;

  assign PCWrite   = ~reset & ((ctl_reg.pcupdate & fetch_gate) | (ctl_reg.branch & zero));
  assign IRWrite   = ~reset & ctl_reg.irwrite & mem_ready;
  assign MemWrite  = ~reset & ctl_reg.memwrite;
  assign RegWrite  = ~reset & ctl_reg.regwrite;
  assign AdrSrc    = ctl_reg.adrsrc;
  assign ResultSrc = ctl_reg.resultsrc;
  assign ALUSrcA   = ctl_reg.alusrca;
  assign ALUSrcB   = ctl_reg.alusrcb;
  assign ImmSrc    = imm_src(op);
  assign Illegal   = (state_reg == DECODE) & ~legal_op(op);

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller against a per-instruction step model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  int checks   = 0;
  int failures = 0;
  bit first_chk = 1'b0;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
`ifdef MC_MEMREADY_EN
    .MemReady   (mem_ready),
`endif
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite),
    .Illegal    (Illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  typedef enum int {S_F, S_D, S_MA, S_MR, S_MWB, S_MW, S_ER, S_EI, S_AWB, S_BEQ, S_JAL} step_t;
  typedef step_t seq_t[$];

  // Step list each instruction class walks through, straight from the instruction descriptions.
  function automatic seq_t plan(logic [6:0] o);
    case (o)
      7'b0000011: return '{S_F, S_D, S_MA, S_MR, S_MWB};
      7'b0100011: return '{S_F, S_D, S_MA, S_MW};
      7'b0110011: return '{S_F, S_D, S_ER, S_AWB};
      7'b0010011: return '{S_F, S_D, S_EI, S_AWB};
      7'b1100011: return '{S_F, S_D, S_BEQ};
      7'b1101111: return '{S_F, S_D, S_JAL, S_AWB};
      default:    return '{S_F, S_D};
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(logic [6:0] o, logic [2:0] f3, logic f7);
    if (f3 == 3'b000) return (o[5] && f7) ? 3'd1 : 3'd0;
    if (f3 == 3'b010) return 3'd5;
    if (f3 == 3'b110) return 3'd3;
    if (f3 == 3'b111) return 3'd2;
    return 3'd0;
  endfunction

  // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc,RegWrite,Illegal}
  function automatic logic [16:0] exp_vec(step_t s, logic [6:0] o, logic [2:0] f3, logic f7,
                                          logic z, logic rdy);
    logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0;
    logic [1:0] res = 0, sa = 0, sb = 0, imm = 0;
    logic [2:0] alu = 0;
    case (s)
      S_F:   begin irw = rdy; pcw = rdy; sb = 2; res = 2; end
      S_D:   begin sa = 1; sb = 1;
               ill = !(o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                 7'b1100011, 7'b1101111}); end
      S_MA:  begin sa = 2; sb = 1; end
      S_MR:  begin adr = 1; end
      S_MWB: begin res = 1; rw = 1; end
      S_MW:  begin adr = 1; mw = 1; end
      S_ER:  begin sa = 2; sb = 0; alu = funct_alu(o, f3, f7); end
      S_EI:  begin sa = 2; sb = 1; alu = funct_alu(o, f3, f7); end
      S_AWB: begin rw = 1; end
      S_BEQ: begin sa = 2; alu = 1; pcw = z; end
      S_JAL: begin sa = 1; sb = 2; pcw = 1; end
      default: ;
    endcase
    if (o == 7'b0100011) imm = 1;
    else if (o == 7'b1100011) imm = 2;
    else if (o == 7'b1101111) imm = 3;
    return {pcw, adr, mw, irw, res, sa, sb, alu, imm, rw, ill};
  endfunction

  // Run one instruction from a posedge; stop_at>=0 aborts after that many cycles.
  task automatic do_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                          input int zsel, input int low_mw, input bit rnd_rdy,
                          input int stop_at, output int mw_cycles);
    seq_t seq = plan(o);
    int   i = 0, cyc = 0, lows = low_mw;
    logic rdy;
    bit   held;
    mw_cycles = 0;
    while (i < seq.size() && cyc < 64 && (stop_at < 0 || cyc < stop_at)) begin
      #1;
      op = o; funct3 = f3; funct7b5 = f7;
      zero = (zsel < 0) ? 1'($urandom) : 1'(zsel);
      rdy = 1'b1;
`ifdef MC_MEMREADY_EN
      if (seq[i] == S_MW && lows > 0) begin rdy = 1'b0; lows--; end
      else if (rnd_rdy) rdy = ($urandom_range(0, 3) != 0);
`endif
      mem_ready = rdy;
      @(negedge clk);
      check($sformatf("cyc_%s_op%b", seq[i].name(), o),
            {15'd0, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ALUControl, ImmSrc, RegWrite, Illegal},
            {15'd0, exp_vec(seq[i], o, f3, f7, zero, rdy)});
      if (first_chk) begin
        check("rel_ir_pc", {30'd0, IRWrite, PCWrite}, 32'd3);
        first_chk = 1'b0;
      end
      if (MemWrite) mw_cycles++;
      held = (seq[i] inside {S_F, S_MR, S_MW}) && !rdy;
      if (!held) i++;
      cyc++;
      @(posedge clk);
    end
    mem_ready = 1'b1;
    $display("instr op=%b f3=%b f7=%b cycles=%0d", o, f3, f7, cyc);
  endtask

  task automatic do_reset(input string tag);
    #1 reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check(tag, {28'd0, PCWrite, MemWrite, IRWrite, RegWrite}, 32'd0);
      @(posedge clk);
    end
    #1 reset = 1'b0;
    first_chk = 1'b1;
  endtask

  logic [6:0] op_tab [7];
  int mw;

  initial begin
    op_tab = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
               7'b1100011, 7'b1101111, 7'b1111111};
    reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_strobes", {28'd0, PCWrite, MemWrite, IRWrite, RegWrite}, 32'd0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    first_chk = 1'b1;

    do_instr(7'b0000011, 3'b010, 1'b0, -1, 0, 1'b0, -1, mw);   // lw
    do_instr(7'b0100011, 3'b010, 1'b0, -1, 0, 1'b0, -1, mw);   // sw
    do_instr(7'b0110011, 3'b000, 1'b0, -1, 0, 1'b0, -1, mw);   // add
    do_instr(7'b0110011, 3'b000, 1'b1, -1, 0, 1'b0, -1, mw);   // sub
    do_instr(7'b0010011, 3'b000, 1'b1, -1, 0, 1'b0, -1, mw);   // addi, Instr[30] ignored
    do_instr(7'b0110011, 3'b010, 1'b0, -1, 0, 1'b0, -1, mw);   // slt
    do_instr(7'b1100011, 3'b000, 1'b0,  1, 0, 1'b0, -1, mw);   // beq taken
    do_instr(7'b1100011, 3'b000, 1'b0,  0, 0, 1'b0, -1, mw);   // beq not taken
    do_instr(7'b1101111, 3'b000, 1'b0, -1, 0, 1'b0, -1, mw);   // jal
    do_instr(7'b1111111, 3'b000, 1'b0, -1, 0, 1'b0, -1, mw);   // illegal

    // abort lw in MEMWB and sw in MEMWRITE: the pending write must be suppressed
    do_instr(7'b0000011, 3'b010, 1'b0, -1, 0, 1'b0, 4, mw);
    do_reset("rst_mid_lw");
    do_instr(7'b0100011, 3'b010, 1'b0, -1, 0, 1'b0, 3, mw);
    do_reset("rst_mid_sw");
    do_instr(7'b0110011, 3'b111, 1'b0, -1, 0, 1'b0, -1, mw);

`ifdef MC_MEMREADY_EN
    do_instr(7'b0100011, 3'b010, 1'b0, -1, 3, 1'b0, -1, mw);
    check("mw_hold", mw, 4);
`endif

    for (int n = 0; n < 150; n++) begin
      logic [6:0] o;
      int k = $urandom_range(0, 7);
      o = (k == 7) ? 7'($urandom) : op_tab[k];
      do_instr(o, 3'($urandom), 1'($urandom), -1, 0, 1'b1, -1, mw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
